// File: rtl/video_timing_gen.sv
// ============================================================================
// Module   : video_timing_gen
// Purpose  : Pixel-rate video timing with sync, blank, coordinates and a test pattern.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module video_timing_gen #(
  parameter int C_res_x = 640,
  parameter int C_hfp   = 16,
  parameter int C_hsync = 96,
  parameter int C_hbp   = 48,
  parameter int C_res_y = 480,
  parameter int C_vfp   = 10,
  parameter int C_vsync = 2,
  parameter int C_vbp   = 33,
  parameter int C_bits  = 10
) (
  input  logic              clk_pixel,
  input  logic              reset,
  input  logic              clk_pixel_ena,
  output logic [C_bits-1:0] o_x,
  output logic [C_bits-1:0] o_y,
  output logic [7:0]        o_r,
  output logic [7:0]        o_g,
  output logic [7:0]        o_b,
  output logic              o_hsync,
  output logic              o_vsync,
  output logic              o_blank,
  output logic              o_frame,
  output logic [7:0]        o_frame_cnt
);

  localparam int H_TOTAL = C_res_x + C_hfp + C_hsync + C_hbp;
  localparam int V_TOTAL = C_res_y + C_vfp + C_vsync + C_vbp;

  localparam logic [C_bits-1:0] H_LAST = C_bits'(H_TOTAL - 1);
  localparam logic [C_bits-1:0] V_LAST = C_bits'(V_TOTAL - 1);
  localparam logic [C_bits-1:0] ACT_X  = C_bits'(C_res_x);
  localparam logic [C_bits-1:0] ACT_Y  = C_bits'(C_res_y);
  localparam logic [C_bits-1:0] HS_BEG = C_bits'(C_res_x + C_hfp);
  localparam logic [C_bits-1:0] HS_END = C_bits'(C_res_x + C_hfp + C_hsync);
  localparam logic [C_bits-1:0] VS_BEG = C_bits'(C_res_y + C_vfp);
  localparam logic [C_bits-1:0] VS_END = C_bits'(C_res_y + C_vfp + C_vsync);
  localparam logic [C_bits-1:0] ONE    = {{(C_bits-1){1'b0}}, 1'b1};

  logic [C_bits-1:0] cx_q, cx_d, cy_q, cy_d;
  logic [C_bits-1:0] x_q, x_d, y_q, y_d;
  logic [7:0]        r_q, r_d, g_q, g_d, b_q, b_d, cnt_q, cnt_d;
  logic              hs_q, hs_d, vs_q, vs_d, blank_q, blank_d, frame_q, frame_d;
  logic              active;

  always_comb begin
    cx_d = (cx_q == H_LAST) ? '0 : cx_q + ONE;
    cy_d = cy_q;
    if (cx_q == H_LAST) begin
      cy_d = (cy_q == V_LAST) ? '0 : cy_q + ONE;
    end

    active  = (cx_q < ACT_X) && (cy_q < ACT_Y);
    hs_d    = (cx_q >= HS_BEG) && (cx_q < HS_END);
    vs_d    = (cy_q >= VS_BEG) && (cy_q < VS_END);
    blank_d = !active;
    frame_d = (cx_q == '0) && (cy_q == '0);
    // Counter advances on the frame-start cycle so the pattern shows the new count.
    cnt_d   = frame_d ? cnt_q + 8'd1 : cnt_q;

    x_d = active ? cx_q : '0;
    y_d = active ? cy_q : '0;
    r_d = active ? 8'(cx_q) : 8'd0;
    g_d = active ? 8'(cy_q) : 8'd0;
    b_d = active ? (cnt_d ^ {cx_q[5], cy_q[5], 6'b0}) : 8'd0;
  end

  always_ff @(posedge clk_pixel or posedge reset) begin
    if (reset) begin
      cx_q    <= '0;
      cy_q    <= '0;
      x_q     <= '0;
      y_q     <= '0;
      r_q     <= 8'd0;
      g_q     <= 8'd0;
      b_q     <= 8'd0;
      cnt_q   <= 8'd0;
      hs_q    <= 1'b0;
      vs_q    <= 1'b0;
      blank_q <= 1'b1;
      frame_q <= 1'b0;
    end else if (clk_pixel_ena) begin
      cx_q    <= cx_d;
      cy_q    <= cy_d;
      x_q     <= x_d;
      y_q     <= y_d;
      r_q     <= r_d;
      g_q     <= g_d;
      b_q     <= b_d;
      cnt_q   <= cnt_d;
      hs_q    <= hs_d;
      vs_q    <= vs_d;
      blank_q <= blank_d;
      frame_q <= frame_d;
    end
  end

  assign o_x         = x_q;
  assign o_y         = y_q;
  assign o_r         = r_q;
  assign o_g         = g_q;
  assign o_b         = b_q;
  assign o_hsync     = hs_q;
  assign o_vsync     = vs_q;
  assign o_blank     = blank_q;
  assign o_frame     = frame_q;
  assign o_frame_cnt = cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_video_timing_gen.sv
// ============================================================================
// Module   : tb_video_timing_gen
// Purpose  : Random-enable bench for video_timing_gen against an arithmetic model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_video_timing_gen;

  logic clk = 1'b0;
  logic rst;
  logic ena;

  always #5 clk = ~clk;

  int unsigned total = 0;
  int unsigned bad   = 0;
  int unsigned n     = 0;
  logic        wrap_seen = 1'b0;
  logic [7:0]  prev_cnt  = 8'd0;

  // Three geometries: default VGA, a tiny one for frame-count wrap, one wide enough for the checker.
  logic [9:0] a_x, a_y, s_x, s_y, p_x, p_y;
  logic [7:0] a_r, a_g, a_b, a_c, s_r, s_g, s_b, s_c, p_r, p_g, p_b, p_c;
  logic       a_hs, a_vs, a_bl, a_fr, s_hs, s_vs, s_bl, s_fr, p_hs, p_vs, p_bl, p_fr;

  video_timing_gen dut_a (
    .clk_pixel(clk), .reset(rst), .clk_pixel_ena(ena),
    .o_x(a_x), .o_y(a_y), .o_r(a_r), .o_g(a_g), .o_b(a_b),
    .o_hsync(a_hs), .o_vsync(a_vs), .o_blank(a_bl), .o_frame(a_fr), .o_frame_cnt(a_c)
  );

  video_timing_gen #(
    .C_res_x(8), .C_hfp(1), .C_hsync(2), .C_hbp(1),
    .C_res_y(4), .C_vfp(1), .C_vsync(1), .C_vbp(0), .C_bits(10)
  ) dut_s (
    .clk_pixel(clk), .reset(rst), .clk_pixel_ena(ena),
    .o_x(s_x), .o_y(s_y), .o_r(s_r), .o_g(s_g), .o_b(s_b),
    .o_hsync(s_hs), .o_vsync(s_vs), .o_blank(s_bl), .o_frame(s_fr), .o_frame_cnt(s_c)
  );

  video_timing_gen #(
    .C_res_x(40), .C_hfp(0), .C_hsync(3), .C_hbp(1),
    .C_res_y(34), .C_vfp(2), .C_vsync(1), .C_vbp(0), .C_bits(10)
  ) dut_p (
    .clk_pixel(clk), .reset(rst), .clk_pixel_ena(ena),
    .o_x(p_x), .o_y(p_y), .o_r(p_r), .o_g(p_g), .o_b(p_b),
    .o_hsync(p_hs), .o_vsync(p_vs), .o_blank(p_bl), .o_frame(p_fr), .o_frame_cnt(p_c)
  );

  // Expected outputs after n enabled edges since reset, from raster arithmetic.
  function automatic logic [63:0] model(int unsigned cnt_en, int rx, int hfp, int hsw, int hbp,
                                        int ry, int vfp, int vsw, int vbp);
    int unsigned pos, h, v, cx, cy, fc, x, y, r, g, b;
    logic act, hs, vs, fr;
    if (cnt_en == 0) return {8'h0, 1'b0, 1'b0, 1'b1, 1'b0, 10'd0, 10'd0, 32'd0};
    pos = cnt_en - 1;
    h   = rx + hfp + hsw + hbp;
    v   = ry + vfp + vsw + vbp;
    cx  = pos % h;
    cy  = (pos / h) % v;
    fc  = (pos / (h * v) + 1) % 256;
    act = (cx < rx) && (cy < ry);
    hs  = (cx >= rx + hfp) && (cx < rx + hfp + hsw);
    vs  = (cy >= ry + vfp) && (cy < ry + vfp + vsw);
    fr  = (cx == 0) && (cy == 0);
    x   = act ? cx : 0;
    y   = act ? cy : 0;
    r   = act ? x % 256 : 0;
    g   = act ? y % 256 : 0;
    b   = act ? (fc ^ ((((x / 32) % 2) * 128) + (((y / 32) % 2) * 64))) : 0;
    return {8'h0, hs, vs, !act, fr, 10'(x), 10'(y), 8'(r), 8'(g), 8'(b), 8'(fc)};
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s n=%0d got=%h exp=%h", tag, n, got, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, "_dflt"}, {8'h0, a_hs, a_vs, a_bl, a_fr, a_x, a_y, a_r, a_g, a_b, a_c},
        model(n, 640, 16, 96, 48, 480, 10, 2, 33));
    chk({tag, "_small"}, {8'h0, s_hs, s_vs, s_bl, s_fr, s_x, s_y, s_r, s_g, s_b, s_c},
        model(n, 8, 1, 2, 1, 4, 1, 1, 0));
    chk({tag, "_patt"}, {8'h0, p_hs, p_vs, p_bl, p_fr, p_x, p_y, p_r, p_g, p_b, p_c},
        model(n, 40, 0, 3, 1, 34, 2, 1, 0));
    if (prev_cnt == 8'd255 && s_c == 8'd0) wrap_seen = 1'b1;
    prev_cnt = s_c;
  endtask

  // Assert reset between edges so the outputs must clear without a clock.
  task automatic do_reset();
    #2 rst = 1'b1;
    n = 0;
    #1 check_all("async_rst");
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    ena = 1'b0;
    repeat (3) @(negedge clk);
    check_all("reset");
    rst = 1'b0;

    for (int cyc = 0; cyc < 40000; cyc++) begin
      if (cyc < 3000)       ena = 1'b1;
      else if (cyc < 5000)  ena = cyc[0];
      else                  ena = ($urandom % 4) != 0;
      if (ena) n++;
      @(negedge clk);
      check_all("run");
      if (cyc == 35000 || (cyc > 35000 && ($urandom % 500) == 0)) do_reset();
    end

    chk("cnt_wrap", {63'h0, wrap_seen}, 64'h1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
